// File: rtl/sram_slave_responder.sv
// Data-port responder: word-addressed RAM with byte strobes and 1-cycle read-first reads,
// plus an MMIO window with a free-running timer and LED, switch and NUM registers.
module sram_slave_responder #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000,
    parameter logic [31:0] CONF_MASK = 32'hffff_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic [31:0] num_data
);

    localparam logic [13:0] OFS_TIMER  = 14'h0000;
    localparam logic [13:0] OFS_LED    = 14'h0001;
    localparam logic [13:0] OFS_SWITCH = 14'h0002;
    localparam logic [13:0] OFS_NUM    = 14'h0003;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       ram_rdata_reg;
    logic [31:0]       mmio_rdata_reg;
    logic              sel_mmio_reg;
    logic [31:0]       timer_reg;
    logic [15:0]       led_reg;
    logic [31:0]       num_reg;

    logic              accept;
    logic              is_mmio;
    logic              is_wr;
    logic [ADDR_W-1:0] ram_idx;
    logic [13:0]       mmio_ofs;
    logic [31:0]       mmio_rd_val;
    logic [31:0]       timer_merged;
    logic [31:0]       num_merged;
    logic [15:0]       led_merged;

    // A request arriving during reset is dropped entirely.
    assign accept   = sram_en && !reset;
    assign is_mmio  = ((sram_addr & CONF_MASK) == CONF_BASE);
    assign is_wr    = |sram_we;
    assign ram_idx  = sram_addr[ADDR_W+1:2];
    assign mmio_ofs = sram_addr[15:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane32
            assign timer_merged[8*gi +: 8] = sram_we[gi] ? sram_wdata[8*gi +: 8] : timer_reg[8*gi +: 8];
            assign num_merged[8*gi +: 8]   = sram_we[gi] ? sram_wdata[8*gi +: 8] : num_reg[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_lane16
            assign led_merged[8*gi +: 8] = sram_we[gi] ? sram_wdata[8*gi +: 8] : led_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        mmio_rd_val = 32'h0;
        case (mmio_ofs)
            OFS_TIMER:  mmio_rd_val = timer_reg;
            OFS_LED:    mmio_rd_val = {16'h0, led_reg};
            OFS_SWITCH: mmio_rd_val = {24'h0, switch};
            OFS_NUM:    mmio_rd_val = num_reg;
            default:    mmio_rd_val = 32'h0;
        endcase
    end

    // Byte-write RAM; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) begin
                    mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first: the old word is captured in the same cycle as any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rdata_reg <= 32'h0;
        end else if (accept && !is_mmio) begin
            ram_rdata_reg <= mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_rdata_reg <= 32'h0;
            sel_mmio_reg   <= 1'b0;
        end else if (accept) begin
            mmio_rdata_reg <= mmio_rd_val;
            sel_mmio_reg   <= is_mmio;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= 32'h0;
            led_reg   <= 16'h0;
            num_reg   <= 32'h0;
        end else begin
            // A timer write wins over the increment for that cycle only.
            if (accept && is_mmio && is_wr && mmio_ofs == OFS_TIMER) begin
                timer_reg <= timer_merged;
            end else begin
                timer_reg <= timer_reg + 32'd1;
            end
            if (accept && is_mmio && is_wr && mmio_ofs == OFS_LED) begin
                led_reg <= led_merged;
            end
            if (accept && is_mmio && is_wr && mmio_ofs == OFS_NUM) begin
                num_reg <= num_merged;
            end
        end
    end

    assign sram_rdata = sel_mmio_reg ? mmio_rdata_reg : ram_rdata_reg;
    assign led        = led_reg;
    assign num_data   = num_reg;

endmodule

// File: tb/tb_sram_slave_responder.sv
// Scoreboard bench for sram_slave_responder: expected rdata queued at request time, popped one edge later.
module tb_sram_slave_responder;

    localparam int          ADDR_W    = 16;
    localparam logic [31:0] CONF_BASE = 32'hbfaf_0000;
    localparam logic [31:0] CONF_MASK = 32'hffff_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic [31:0] num_data;

    always #5 clk = ~clk;

    sram_slave_responder #(
        .ADDR_W    (ADDR_W),
        .CONF_BASE (CONF_BASE),
        .CONF_MASK (CONF_MASK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led),
        .switch     (switch),
        .num_data   (num_data)
    );

    typedef struct {
        string       tag;
        bit          chk;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] last_rdata;
    bit          last_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] we);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = we[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // One accepted request; timer reads have no model, so their expected value is passed in.
    task automatic req(input string tag, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit tchk, input logic [31:0] timer_exp);
        logic [31:0] e;
        logic [31:0] tmp;
        bit          c;
        int          idx;
        sb_t         s;
        @(negedge clk);
        sram_en    = 1'b1;
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        c = 1'b1;
        e = 32'h0;
        if ((addr & CONF_MASK) == CONF_BASE) begin
            case (addr[15:2])
                14'h0: begin e = timer_exp; c = tchk; end
                14'h1: begin
                    e = {16'h0, led_m};
                    tmp = merge({16'h0, led_m}, wdata, {2'b00, we[1:0]});
                    led_m = tmp[15:0];
                end
                14'h2: e = {24'h0, switch};
                14'h3: begin e = num_m; num_m = merge(num_m, wdata, we); end
                default: e = 32'h0;
            endcase
        end else begin
            idx = int'(addr[ADDR_W+1:2]);
            if (ram_m.exists(idx)) begin
                e = ram_m[idx];
            end else begin
                c = 1'b0;
            end
            if (we != 4'h0) ram_m[idx] = merge(e, wdata, we);
        end
        sb_q.push_back('{tag, c, e});
        @(posedge clk);
        #1;
        s = sb_q.pop_front();
        if (s.chk) check_val(s.tag, sram_rdata, s.exp);
        check_val({s.tag, "_led"}, {16'h0, led}, {16'h0, led_m});
        check_val({s.tag, "_num"}, num_data, num_m);
        last_rdata = s.exp;
        last_valid = s.chk;
    endtask

    // Idle cycles with en=0; rdata must hold the last value.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sram_en = 1'b0;
            @(posedge clk);
            #1;
            if (last_valid) check_val("hold", sram_rdata, last_rdata);
        end
    endtask

    initial begin
        reset      = 1'b1;
        sram_en    = 1'b1;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        switch     = 8'h00;
        led_m      = 16'h0;
        num_m      = 32'h0;
        last_rdata = 32'h0;
        last_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_rdata", sram_rdata, 32'h0);
            check_val("rst_led", {16'h0, led}, 32'h0);
            check_val("rst_num", num_data, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        // RAM full write, readback, partial write, read-first and back-to-back merge
        req("wr100",    4'hf,    32'h100, 32'h1234_5678, 1'b0, 32'h0);
        req("rd100",    4'h0,    32'h100, 32'h0,         1'b0, 32'h0);
        req("wr100_b1", 4'b0010, 32'h100, 32'hAABB_CCDD, 1'b0, 32'h0);
        req("rd100_b1", 4'h0,    32'h100, 32'h0,         1'b0, 32'h0);
        req("wr100_b3", 4'b1000, 32'h100, 32'h9900_0000, 1'b0, 32'h0);
        req("rd100_b2b",4'h0,    32'h100, 32'h0,         1'b0, 32'h0);
        req("rd_alias", 4'h0,    32'h0004_0100, 32'h0,   1'b0, 32'h0);
        idle(2);

        // Timer load and wrap
        req("tmr_wr", 4'hf, CONF_BASE, 32'hFFFF_FFFE, 1'b0, 32'h0);
        idle(1);
        req("tmr_rd1", 4'h0, CONF_BASE, 32'h0, 1'b1, 32'hFFFF_FFFF);
        idle(1);
        req("tmr_rd3", 4'h0, CONF_BASE, 32'h0, 1'b1, 32'h0000_0001);

        // MMIO registers and isolation from RAM
        req("wr_ram4", 4'hf, 32'h4, 32'hCAFE_F00D, 1'b0, 32'h0);
        req("wr_led",  4'hf, CONF_BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, 32'h0);
        req("wr_num",  4'hf, CONF_BASE + 32'hC, 32'h0000_0005, 1'b0, 32'h0);
        switch = 8'h5A;
        req("rd_sw",   4'h0, CONF_BASE + 32'h8, 32'h0, 1'b0, 32'h0);
        req("wr_sw",   4'hf, CONF_BASE + 32'h8, 32'hFFFF_FFFF, 1'b0, 32'h0);
        req("rd_led",  4'h0, CONF_BASE + 32'h4, 32'h0, 1'b0, 32'h0);
        req("wr_led_hi", 4'b1100, CONF_BASE + 32'h4, 32'h1234_0000, 1'b0, 32'h0);
        req("rd_num",  4'h0, CONF_BASE + 32'hC, 32'h0, 1'b0, 32'h0);
        req("wr_unmap",4'hf, CONF_BASE + 32'h10, 32'h7777_7777, 1'b0, 32'h0);
        req("rd_unmap",4'h0, CONF_BASE + 32'h10, 32'h0, 1'b0, 32'h0);
        req("rd_ram4", 4'h0, 32'h4, 32'h0, 1'b0, 32'h0);
        idle(2);

        // Reset while a write is presented: the write is dropped and the timer restarts
        req("wr200", 4'hf, 32'h200, 32'h0BAD_F00D, 1'b0, 32'h0);
        @(negedge clk);
        reset      = 1'b1;
        sram_en    = 1'b1;
        sram_we    = 4'hf;
        sram_addr  = 32'h200;
        sram_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        led_m = 16'h0;
        num_m = 32'h0;
        check_val("rst2_rdata", sram_rdata, 32'h0);
        check_val("rst2_led", {16'h0, led}, 32'h0);
        check_val("rst2_num", num_data, 32'h0);
        reset = 1'b0;
        req("tmr_after_rst", 4'h0, CONF_BASE, 32'h0, 1'b1, 32'h0);
        req("rd200", 4'h0, 32'h200, 32'h0, 1'b0, 32'h0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
